// File: rtl/spi_reg_bridge_pkg.sv
// Shared definitions for the SPI-to-register bridge: FSM states and command byte layout.
// Imported by the bridge top; the synchroniser has no dependency on it.
package spi_reg_bridge_pkg;

    typedef enum logic [2:0] {
        WAIT_SS = 3'd0,
        IDLE    = 3'd1,
        CMD     = 3'd2,
        WR      = 3'd3,
        RD      = 3'd4,
        DISCARD = 3'd5
    } state_t;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_ADDR_MSB = 6;

endpackage

// File: rtl/spi_reg_bridge_sync_edge.sv
// Multi-flop synchroniser with a registered rising-edge pulse aligned to the synchronised level.
// Latency: STAGES clk to lvl_o/rise_o; no backpressure.
module spi_reg_bridge_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstb,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              rise_q;

    // rise_q is computed from the stage feeding the output flop so it asserts in the same cycle as lvl_o
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync_q <= {STAGES{RST_VAL}};
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            rise_q <= sync_q[STAGES-2] & ~sync_q[STAGES-1];
        end
    end

    assign lvl_o  = sync_q[STAGES-1];
    assign rise_o = rise_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// Converts SPI slave bytes into register writes/reads and supplies read-back bytes for MISO.
// Latency: done edge -> strobe SYNC_STAGES+1 clk, -> tdata SYNC_STAGES+2 clk; no backpressure.
module spi_reg_bridge
    import spi_reg_bridge_pkg::*;
#(
    parameter int         ADDR_W      = 4,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_TDATA  = 8'hFF
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ss,
    input  logic              done,
    input  logic [7:0]        rdata,
    output logic [7:0]        tdata,
    output logic              ten,
    output logic              reg_we,
    output logic              reg_re,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    input  logic [7:0]        reg_rdata,
    output logic              frame_err
);

    logic ss_s, ss_rise, byte_evt, done_lvl_unused;

    spi_reg_bridge_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_done_sync (
        .clk(clk), .rstb(rstb), .d_i(done), .lvl_o(done_lvl_unused), .rise_o(byte_evt)
    );

    spi_reg_bridge_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rstb(rstb), .d_i(ss), .lvl_o(ss_s), .rise_o(ss_rise)
    );

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       ptr_q, ptr_d, reg_addr_q, reg_addr_d;
    logic [7:0]              reg_wdata_q, reg_wdata_d, tdata_q, tdata_d;
    logic                    reg_we_q, reg_we_d, reg_re_q, reg_re_d;
    logic                    frame_err_q, frame_err_d;
    logic [SYNC_STAGES-1:0]  settle_q;
    logic                    settled;
    logic [CMD_ADDR_MSB:0]   cmd_addr;
    logic                    cmd_bad;

    // ss_s reads as its reset value until the chain has refilled; don't trust it before then
    assign settled  = settle_q[SYNC_STAGES-1];
    assign cmd_addr = rdata[CMD_ADDR_MSB:0];
    assign cmd_bad  = (cmd_addr >> ADDR_W) != '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        frame_err_d = frame_err_q;
        tdata_d     = reg_re_q ? reg_rdata : tdata_q;
        case (state_q)
            WAIT_SS: if (settled && ss_s) state_d = IDLE;
            IDLE: begin
                if (!ss_s) begin
                    state_d     = CMD;
                    frame_err_d = 1'b0;
                end
            end
            default: begin
                // Active states are only entered with ss_s low, so its rising pulse marks every deselect
                if (ss_rise) begin
                    state_d = IDLE;
                    tdata_d = IDLE_TDATA;
                end else if (byte_evt) begin
                    case (state_q)
                        CMD: begin
                            if (cmd_bad) begin
                                frame_err_d = 1'b1;
                                state_d     = DISCARD;
                            end else if (rdata[CMD_RW_BIT]) begin
                                state_d    = RD;
                                reg_addr_d = cmd_addr[ADDR_W-1:0];
                                reg_re_d   = 1'b1;
                                ptr_d      = cmd_addr[ADDR_W-1:0] + 1'b1;
                            end else begin
                                state_d = WR;
                                ptr_d   = cmd_addr[ADDR_W-1:0];
                            end
                        end
                        WR: begin
                            reg_addr_d  = ptr_q;
                            reg_wdata_d = rdata;
                            reg_we_d    = 1'b1;
                            ptr_d       = ptr_q + 1'b1;
                        end
                        RD: begin
                            reg_addr_d = ptr_q;
                            reg_re_d   = 1'b1;
                            ptr_d      = ptr_q + 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= WAIT_SS;
            ptr_q       <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            frame_err_q <= 1'b0;
            tdata_q     <= IDLE_TDATA;
            settle_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            frame_err_q <= frame_err_d;
            tdata_q     <= tdata_d;
            settle_q    <= {settle_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign tdata     = tdata_q;
    assign ten       = (state_q != WAIT_SS) && !ss_s;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: byte-level SPI slave model, register file model, strobe scoreboard.
module tb_spi_reg_bridge;

    logic       clk = 1'b0;
    logic       rstb, ss, done, load_regs;
    logic [7:0] rdata, tdata, reg_wdata, reg_rdata;
    logic       ten, reg_we, reg_re, frame_err;
    logic [3:0] reg_addr;

    always #5 clk = ~clk;

    spi_reg_bridge dut (
        .clk(clk), .rstb(rstb), .ss(ss), .done(done), .rdata(rdata), .tdata(tdata), .ten(ten),
        .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .frame_err(frame_err)
    );

    logic [7:0] regs [16];
    assign reg_rdata = regs[reg_addr];

    always @(posedge clk) begin
        if (load_regs) begin
            for (int i = 0; i < 16; i++)
                regs[i] <= (i == 5) ? 8'h11 : (i == 6) ? 8'h22 : (i == 7) ? 8'h33 : 8'h40 + 8'(i);
        end else if (reg_we) begin
            regs[reg_addr] <= reg_wdata;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    logic [11:0] exp_wr_q [$];
    logic [3:0]  exp_rd_q [$];

    always @(negedge clk) begin
        if (rstb) begin
            if (reg_we) begin
                if (exp_wr_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_we actual=%0h required=none", {reg_addr, reg_wdata});
                end else begin
                    chk("we_addr_data", {20'd0, reg_addr, reg_wdata}, {20'd0, exp_wr_q.pop_front()});
                end
            end
            if (reg_re) begin
                if (exp_rd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_re actual=%0h required=none", reg_addr);
                end else begin
                    chk("re_addr", {28'd0, reg_addr}, {28'd0, exp_rd_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One byte: slave loads tdata at byte start, shifts for ~60 clk, raises done, short gap
    task automatic send_byte(input logic [7:0] b, output logic [7:0] miso, output int lat);
        miso  = tdata;
        done  = 1'b0;
        rdata = b;
        tick(60);
        done = 1'b1;
        lat  = 99;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            if (lat == 99 && (reg_we || reg_re)) lat = i;
        end
    endtask

    task automatic start_frame();
        ss = 1'b0;
        tick(10);
    endtask

    task automatic end_frame();
        ss = 1'b1;
        tick(10);
    endtask

    typedef struct {
        int               n;
        logic [0:3][7:0]  b;
        logic [0:3][7:0]  miso;
        int               nwr;
        logic [0:2][11:0] wr;
        int               nrd;
        logic [0:3][3:0]  rd;
        logic             err;
    } vec_t;

    function automatic vec_t mkv(int n, logic [31:0] b, logic [31:0] m, int nwr, logic [35:0] wr,
                                 int nrd, logic [15:0] rd, logic err);
        vec_t v;
        v.n = n; v.b = b; v.miso = m; v.nwr = nwr; v.wr = wr; v.nrd = nrd; v.rd = rd; v.err = err;
        return v;
    endfunction

    vec_t       vecs [9];
    vec_t       v;
    logic [7:0] m;
    int         lat;
    logic       exp_strobe;

    initial begin
        rstb = 1'b0; ss = 1'b1; done = 1'b0; rdata = 8'h00; load_regs = 1'b1;
        tick(3);
        chk("rst_tdata", {24'd0, tdata}, 32'hFF);
        chk("rst_ten", {31'd0, ten}, 0);
        chk("rst_we", {31'd0, reg_we}, 0);
        chk("rst_re", {31'd0, reg_re}, 0);
        chk("rst_addr", {28'd0, reg_addr}, 0);
        chk("rst_wdata", {24'd0, reg_wdata}, 0);
        chk("rst_err", {31'd0, frame_err}, 0);
        load_regs = 1'b0;
        rstb = 1'b1;
        tick(6);
        chk("idle_ten", {31'd0, ten}, 0);
        chk("idle_tdata", {24'd0, tdata}, 32'hFF);

        vecs[0] = mkv(3, 32'h03A55A00, 32'hFFFFFF00, 2, 36'h3A5_45A_000, 0, 16'h0000, 1'b0);
        vecs[1] = mkv(4, 32'h85000000, 32'hFF112233, 0, 36'h0,           4, 16'h5678, 1'b0);
        vecs[2] = mkv(3, 32'h0F010200, 32'hFFFFFF00, 2, 36'hF01_002_000, 0, 16'h0000, 1'b0);
        vecs[3] = mkv(3, 32'h90000000, 32'hFFFFFF00, 0, 36'h0,           0, 16'h0000, 1'b1);
        vecs[4] = mkv(2, 32'h83000000, 32'hFFA50000, 0, 36'h0,           2, 16'h3400, 1'b0);
        vecs[5] = mkv(3, 32'h8F000000, 32'hFF010200, 0, 36'h0,           3, 16'hF010, 1'b0);
        vecs[6] = mkv(2, 32'hFF000000, 32'hFFFF0000, 0, 36'h0,           0, 16'h0000, 1'b1);
        vecs[7] = mkv(2, 32'h0AC30000, 32'hFFFF0000, 1, 36'hAC3_000_000, 0, 16'h0000, 1'b0);
        vecs[8] = mkv(3, 32'h8A000000, 32'hFFC34B00, 0, 36'h0,           3, 16'hABC0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            for (int w = 0; w < v.nwr; w++) exp_wr_q.push_back(v.wr[w]);
            for (int r = 0; r < v.nrd; r++) exp_rd_q.push_back(v.rd[r]);
            start_frame();
            chk($sformatf("v%0d_ten_active", i), {31'd0, ten}, 1);
            for (int k = 0; k < v.n; k++) begin
                send_byte(v.b[k], m, lat);
                chk($sformatf("v%0d_miso%0d", i, k), {24'd0, m}, {24'd0, v.miso[k]});
                exp_strobe = !v.err && (k > 0 || v.b[0][7]);
                if (exp_strobe) chk($sformatf("v%0d_lat%0d", i, k), {31'd0, lat <= 3}, 1);
                else            chk($sformatf("v%0d_nostrobe%0d", i, k), lat, 99);
            end
            end_frame();
            chk($sformatf("v%0d_err", i), {31'd0, frame_err}, {31'd0, v.err});
            chk($sformatf("v%0d_tdata_end", i), {24'd0, tdata}, 32'hFF);
            chk($sformatf("v%0d_ten_end", i), {31'd0, ten}, 0);
            chk($sformatf("v%0d_wr_left", i), exp_wr_q.size(), 0);
            chk($sformatf("v%0d_rd_left", i), exp_rd_q.size(), 0);
        end

        // Abort: deselect lands in the same clk as the 2nd data byte's event
        exp_rd_q.push_back(4'h5);
        exp_rd_q.push_back(4'h6);
        start_frame();
        send_byte(8'h85, m, lat);
        chk("abort_miso0", {24'd0, m}, 32'hFF);
        send_byte(8'h00, m, lat);
        chk("abort_miso1", {24'd0, m}, 32'h11);
        m = tdata;
        chk("abort_miso2", {24'd0, m}, 32'h22);
        done = 1'b0; rdata = 8'h00;
        tick(60);
        done = 1'b1; ss = 1'b1;
        tick(10);
        chk("abort_tdata", {24'd0, tdata}, 32'hFF);
        chk("abort_ten", {31'd0, ten}, 0);
        chk("abort_rd_left", exp_rd_q.size(), 0);
        exp_wr_q.push_back(12'hC5E);
        start_frame();
        send_byte(8'h0C, m, lat);
        send_byte(8'h5E, m, lat);
        chk("post_abort_lat", {31'd0, lat <= 3}, 1);
        end_frame();
        chk("post_abort_wr_left", exp_wr_q.size(), 0);

        // Reset while selected: bytes ignored until ss cycles high then low
        start_frame();
        send_byte(8'h02, m, lat);
        rstb = 1'b0;
        tick(2);
        chk("midrst_addr", {28'd0, reg_addr}, 0);
        chk("midrst_wdata", {24'd0, reg_wdata}, 0);
        chk("midrst_tdata", {24'd0, tdata}, 32'hFF);
        rstb = 1'b1;
        tick(5);
        send_byte(8'h99, m, lat);
        chk("midrst_nostrobe", lat, 99);
        chk("midrst_ten", {31'd0, ten}, 0);
        chk("midrst_tdata2", {24'd0, tdata}, 32'hFF);
        end_frame();
        start_frame();
        chk("rejoin_ten", {31'd0, ten}, 1);
        exp_wr_q.push_back(12'h244);
        send_byte(8'h02, m, lat);
        send_byte(8'h44, m, lat);
        end_frame();
        chk("rejoin_wr_left", exp_wr_q.size(), 0);
        chk("rejoin_err", {31'd0, frame_err}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
